dmem_responder: RTL and testbench

Multi-cycle data-memory responder for the pipelined core. It serves load and store requests from the core's memory stage over a valid/ready request channel and a valid/ready response channel. Internally it holds a 4 KB word array with byte-enable writes. Its fixed access latency lets the core's stall logic be exercised.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 51 +++++
 rtl/dmem_responder.sv | 177 +++++++++++++++++
 tb/tb_dmem_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and default parameters for the data-memory
//                responder (FSM state encoding, latency and array size).
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Responder control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_LAT_DEFAULT    = 2;
  localparam int DMEM_ADDR_W_DEFAULT = 10;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Synchronous 2^ADDR_W x 32 RAM with per-byte write enables
//                and a registered read port. Write-first: a write returns
//                the merged word on the same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];
  logic [31:0] r_rdata;
  logic [31:0] w_merged;

  // Word as it will look after this cycle's byte-lane write
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign w_merged[8*i +: 8] = (i_we && i_be[i]) ? i_wdata[8*i +: 8]
                                                  : r_mem[i_addr][8*i +: 8];
  end

  // Array storage: only enabled lanes are written, contents survive reset
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      r_mem[i_addr] <= w_merged;
    end
  end

  // Registered read port, returning the post-write word on a write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_en) begin
      r_rdata <= w_merged;
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Fixed-latency data-memory responder with valid/ready request
//                and response channels, byte-enable stores and address error
//                detection. Supports back-to-back requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = DMEM_ADDR_W_DEFAULT,
  parameter int LATENCY = DMEM_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  // With a single-cycle latency the request goes straight to RESP, so the
  // array must be driven from the live request rather than the capture regs.
  localparam bit         c_single = (LATENCY == 1);
  localparam logic [3:0] c_cnt_init = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  dmem_state_t       r_state;
  dmem_state_t       w_state_nxt;
  logic [3:0]        r_cnt;
  logic              w_accept;
  logic              w_enter_resp;

  logic              r_we;
  logic [ADDR_W-1:0] r_word;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic              r_err;

  logic              r_resp_valid;
  logic              r_resp_err;
  logic              r_rd_ok;

  logic              w_req_err;
  logic              w_op_we;
  logic [ADDR_W-1:0] w_op_word;
  logic [3:0]        w_op_be;
  logic [31:0]       w_op_wdata;
  logic              w_op_err;
  logic [31:0]       w_ram_q;

  assign w_req_err = (|req_addr[1:0]) || (|req_addr[31:ADDR_W+2]);

  // Operation being committed on the edge that enters RESP
  assign w_op_we    = c_single ? req_we               : r_we;
  assign w_op_word  = c_single ? req_addr[ADDR_W+1:2] : r_word;
  assign w_op_be    = c_single ? req_be               : r_be;
  assign w_op_wdata = c_single ? req_wdata            : r_wdata;
  assign w_op_err   = c_single ? w_req_err            : r_err;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, acceptance and request-ready decode
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    req_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept     = 1'b1;
          w_enter_resp = c_single;
          w_state_nxt  = c_single ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_enter_resp = 1'b1;
          w_state_nxt  = RESP;
        end
      end
      RESP: begin
        req_ready = resp_ready;
        if (resp_ready) begin
          if (req_valid) begin
            w_accept     = 1'b1;
            w_enter_resp = c_single;
            w_state_nxt  = c_single ? RESP : WAIT;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latency down-counter, loaded at acceptance and run down in WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= c_cnt_init;
    end else if (r_state == WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Request capture at acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_word  <= '0;
      r_be    <= 4'd0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_word  <= req_addr[ADDR_W+1:2];
      r_be    <= req_be;
      r_wdata <= req_wdata;
      r_err   <= w_req_err;
    end
  end

  // Response flags: set on entering RESP, cleared when the response retires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rd_ok      <= 1'b0;
    end else if (w_enter_resp) begin
      r_resp_valid <= 1'b1;
      r_resp_err   <= w_op_err;
      r_rd_ok      <= !w_op_we && !w_op_err;
    end else if (r_state == RESP && resp_ready) begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rd_ok      <= 1'b0;
    end
  end

  // Erroring stores never reach the array
  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_enter_resp),
    .i_we    (w_op_we && !w_op_err),
    .i_be    (w_op_be),
    .i_addr  (w_op_word),
    .i_wdata (w_op_wdata),
    .o_rdata (w_ram_q)
  );

  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_rd_ok ? w_ram_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Directed self-checking bench for dmem_responder, one
//                instance at LATENCY=2 and one at LATENCY=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic        clk;
  logic        rst;

  // LATENCY=2 instance
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  // LATENCY=1 instance
  logic        b_req_valid, b_req_ready, b_req_we;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [3:0]  b_req_be;
  logic        b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_resp_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_be(b_req_be), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One complete transaction on the LATENCY=2 instance with resp_ready=1.
  // Latency is counted in cycles from the acceptance cycle to the first
  // cycle showing resp_valid.
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    int  k;
    bit  seen;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_be     = be;
    req_wdata  = wd;
    resp_ready = 1'b1;
    @(posedge clk);
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      req_valid = 1'b0;
      k++;
      if (resp_valid) seen = 1'b1;
    end
    check({tag, ".valid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, ".lat"},   k, 32'd2);
    check({tag, ".rdata"}, resp_rdata, exp_rd);
    check({tag, ".err"},   {31'd0, resp_err}, {31'd0, exp_err});
    @(posedge clk);
  endtask

  // One cycle of the LATENCY=1 stream: check the response to the previous
  // request, then present the next one.
  task automatic b_step(input string tag, input logic [31:0] exp_rd,
                        input logic nv, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd);
    @(negedge clk);
    check({tag, ".valid"}, {31'd0, b_resp_valid}, 32'd1);
    check({tag, ".rdata"}, b_resp_rdata, exp_rd);
    check({tag, ".ready"}, {31'd0, b_req_ready}, 32'd1);
    b_req_valid = nv;
    b_req_we    = we;
    b_req_addr  = addr;
    b_req_be    = 4'hF;
    b_req_wdata = wd;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;
    resp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_be = '0; b_req_wdata = '0;
    b_resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst.req_ready",  {31'd0, req_ready},  32'd1);
    check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst.resp_rdata", resp_rdata,          32'd0);
    check("rst.resp_err",   {31'd0, resp_err},   32'd0);

    // Word store and reload
    do_req("st10", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'd0, 1'b0);
    do_req("ld10", 1'b0, 32'h10, 4'hF, 32'd0, 32'hDEADBEEF, 1'b0);

    // Byte merge
    do_req("st20",  1'b1, 32'h20, 4'hF, 32'h11223344, 32'd0, 1'b0);
    do_req("st20b", 1'b1, 32'h20, 4'b0010, 32'h0000AA00, 32'd0, 1'b0);
    do_req("ld20",  1'b0, 32'h20, 4'hF, 32'd0, 32'h1122AA44, 1'b0);

    // Store with no lanes enabled leaves the word alone
    do_req("st10be0", 1'b1, 32'h10, 4'h0, 32'h0, 32'd0, 1'b0);
    do_req("ld10be0", 1'b0, 32'h10, 4'hF, 32'd0, 32'hDEADBEEF, 1'b0);

    // Errors: misaligned load, out-of-range store aliasing word 0
    do_req("ld22",   1'b0, 32'h22, 4'hF, 32'd0, 32'd0, 1'b1);
    do_req("st0",    1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 32'd0, 1'b0);
    do_req("st1000", 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 32'd0, 1'b1);
    do_req("ld0",    1'b0, 32'h0, 4'hF, 32'd0, 32'hCAFEF00D, 1'b0);

    // Response backpressure, next request queued behind it
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h10;
    check("bp.wait_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("bp.valid", {31'd0, resp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp.hold_rdata", resp_rdata, 32'h1122AA44);
      check("bp.hold_ready", {31'd0, req_ready}, 32'd0);
      check("bp.hold_valid", {31'd0, resp_valid}, 32'd1);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    check("bp.ready_comb", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp.next_wait", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    check("bp.next_valid", {31'd0, resp_valid}, 32'd1);
    check("bp.next_rdata", resp_rdata, 32'hDEADBEEF);
    @(posedge clk);

    // Reset during WAIT of a store drops the store
    do_req("st30", 1'b1, 32'h30, 4'hF, 32'h12345678, 32'd0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_be = 4'hF; req_wdata = 32'h55555555;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rmid.wait_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("rmid.req_ready",  {31'd0, req_ready},  32'd1);
    check("rmid.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rmid.resp_rdata", resp_rdata,          32'd0);
    check("rmid.resp_err",   {31'd0, resp_err},   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_req("ld30", 1'b0, 32'h30, 4'hF, 32'd0, 32'h12345678, 1'b0);

    // LATENCY=1 back-to-back stream: one response per cycle
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'h40; b_req_be = 4'hF;
    b_req_wdata = 32'hA5A5A5A5;
    check("l1.ready0", {31'd0, b_req_ready}, 32'd1);
    b_step("l1.st40", 32'd0,        1'b1, 1'b1, 32'h44, 32'hB1B1B1B1);
    b_step("l1.st44", 32'd0,        1'b1, 1'b0, 32'h44, 32'd0);
    b_step("l1.ld44", 32'hB1B1B1B1, 1'b1, 1'b0, 32'h40, 32'd0);
    b_step("l1.ld40", 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0,  32'd0);
    @(negedge clk);
    check("l1.idle_valid", {31'd0, b_resp_valid}, 32'd0);
    check("l1.idle_ready", {31'd0, b_req_ready},  32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
